hazard_stall_ctrl: RTL and testbench

Parametrised hazard-detection and stall controller for the 5-stage MIPS pipeline, placed between the ID-stage decoder and the IF/ID, ID/EX and PC enables. It generalises the existing combinational load-use and branch hazard check in four ways:

- configurable register-address width;
- multi-cycle load latency, tracked by a stall FSM;
- hazard checks against both EX and MEM producers;
- taken-branch IF/ID flush generation.

An optional saturating stall-cycle counter supports performance measurement.

---
 rtl/hazard_stall_ctrl.sv | 80 ++++++++
 tb/tb_hazard_stall_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use/branch hazard stall FSM with IF/ID flush.
// HAZ_STALL_STAT_EN builds the saturating stall_cycles counter; otherwise it reads 0.
module hazard_stall_ctrl #(
   parameter int RW       = 5,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic          id_use_rs,
   input  logic          id_use_rt,
   input  logic          id_branch,
   input  logic          id_jr,
   input  logic          id_taken,
   input  logic [RW-1:0] ex_dst,
   input  logic          ex_regwrite,
   input  logic          ex_memread,
   input  logic [RW-1:0] mem_dst,
   input  logic          mem_regwrite,
   input  logic          mem_memread,
   output logic          pc_en,
   output logic          ifid_en,
   output logic          idex_bubble,
   output logic          ifid_flush,
   output logic [31:0]   stall_cycles
);
   typedef enum logic {RUN, LWAIT} state_t;
   localparam logic [CNT_W-1:0] LD = CNT_W'(LOAD_LAT - 1);
   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             m_ex, m_mem, lu, bx, bm, stall, act;
   assign m_ex  = (ex_dst != '0) && ((id_use_rs && id_rs == ex_dst) || (id_use_rt && id_rt == ex_dst));
   assign m_mem = (mem_dst != '0) && ((id_use_rs && id_rs == mem_dst) || (id_use_rt && id_rt == mem_dst));
   assign lu    = ex_memread && ex_regwrite && m_ex;
   assign bx    = (id_branch || id_jr) && ex_regwrite && m_ex;
   assign bm    = (id_branch || id_jr) && mem_memread && mem_regwrite && m_mem;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall     = (state == LWAIT) || lu || bx || bm;
      if (state == RUN) begin
         if (lu && LOAD_LAT > 1) begin
            state_nxt = LWAIT;
            cnt_nxt   = LD;
         end
      end else begin
         cnt_nxt   = cnt - CNT_W'(1);
         state_nxt = (cnt == CNT_W'(1)) ? RUN : LWAIT;
      end
   end
   // reset masks every output to the free-running, no-flush condition
   assign act         = rst_n && stall;
   assign pc_en       = !act;
   assign ifid_en     = !act;
   assign idex_bubble = act;
   assign ifid_flush  = rst_n && id_taken && !stall;
`ifdef HAZ_STALL_STAT_EN
   logic [31:0] stat;
   always_ff @(posedge clk) begin
      if (!rst_n)
         stat <= '0;
      else if (idex_bubble && stat != '1)
         stat <= stat + 32'd1;
   end
   assign stall_cycles = stat;
`else
   assign stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed scoreboard bench over LOAD_LAT = 1, 3 and 5 instances.
module tb_hazard_stall_ctrl;
   logic       clk = 0, rst_n;
   logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
   logic       id_use_rs, id_use_rt, id_branch, id_jr, id_taken;
   logic       ex_regwrite, ex_memread, mem_regwrite, mem_memread;
   logic       pc1, if1, bb1, fl1, pc3, if3, bb3, fl3, pc5, if5, bb5, fl5;
   logic [31:0] sc1, sc3, sc5;
   int comps = 0, errs = 0;
   int x1 = 0, x3 = 0, x5 = 0;
   typedef struct {
      string      tag;
      logic [3:0] e1, e3, e5;
      logic [31:0] s1, s3, s5;
   } exp_t;
   exp_t q[$];
   localparam logic [3:0] N = 4'b1100, S = 4'b0010, F = 4'b1101;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.RW(5), .LOAD_LAT(1), .CNT_W(3)) u1 (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
      .id_use_rt(id_use_rt), .id_branch(id_branch), .id_jr(id_jr), .id_taken(id_taken),
      .ex_dst(ex_dst), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_dst(mem_dst),
      .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .pc_en(pc1), .ifid_en(if1),
      .idex_bubble(bb1), .ifid_flush(fl1), .stall_cycles(sc1));
   hazard_stall_ctrl #(.RW(5), .LOAD_LAT(3), .CNT_W(3)) u3 (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
      .id_use_rt(id_use_rt), .id_branch(id_branch), .id_jr(id_jr), .id_taken(id_taken),
      .ex_dst(ex_dst), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_dst(mem_dst),
      .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .pc_en(pc3), .ifid_en(if3),
      .idex_bubble(bb3), .ifid_flush(fl3), .stall_cycles(sc3));
   hazard_stall_ctrl #(.RW(5), .LOAD_LAT(5), .CNT_W(3)) u5 (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
      .id_use_rt(id_use_rt), .id_branch(id_branch), .id_jr(id_jr), .id_taken(id_taken),
      .ex_dst(ex_dst), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_dst(mem_dst),
      .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .pc_en(pc5), .ifid_en(if5),
      .idex_bubble(bb5), .ifid_flush(fl5), .stall_cycles(sc5));

   task automatic clr();
      {id_rs, id_rt, ex_dst, mem_dst} = '0;
      {id_use_rs, id_use_rt, id_branch, id_jr, id_taken} = '0;
      {ex_regwrite, ex_memread, mem_regwrite, mem_memread} = '0;
   endtask

   task automatic cmp(string tag, logic [31:0] o, logic [31:0] e);
      comps++;
      assert (o === e) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   function automatic logic [31:0] sx(int v);
`ifdef HAZ_STALL_STAT_EN
      return 32'(v);
`else
      return 32'(v * 0);
`endif
   endfunction

   // one pipeline cycle: expectation queued with the inputs, checked at the falling edge
   task automatic step(string tag, logic [3:0] e1, logic [3:0] e3, logic [3:0] e5);
      exp_t e;
      e = '{tag: tag, e1: e1, e3: e3, e5: e5, s1: sx(x1), s3: sx(x3), s5: sx(x5)};
      q.push_back(e);
      @(negedge clk);
      e = q.pop_front();
      cmp({e.tag, "/lat1"}, 32'({pc1, if1, bb1, fl1}), 32'(e.e1));
      cmp({e.tag, "/lat3"}, 32'({pc3, if3, bb3, fl3}), 32'(e.e3));
      cmp({e.tag, "/lat5"}, 32'({pc5, if5, bb5, fl5}), 32'(e.e5));
      cmp({e.tag, "/cnt1"}, sc1, e.s1);
      cmp({e.tag, "/cnt3"}, sc3, e.s3);
      cmp({e.tag, "/cnt5"}, sc5, e.s5);
      if (!rst_n) begin
         x1 = 0; x3 = 0; x5 = 0;
      end else begin
         x1 += int'(e1[1]); x3 += int'(e3[1]); x5 += int'(e5[1]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic load_use(logic [4:0] r, bit use_rt);
      clr();
      ex_memread = 1; ex_regwrite = 1; ex_dst = r;
      if (use_rt) begin id_rt = r; id_use_rt = 1; end
      else begin id_rs = r; id_use_rs = 1; end
   endtask

   initial begin
      rst_n = 0;
      load_use(5, 0);
      @(posedge clk); #1;
      step("rst_a", N, N, N);
      step("rst_b", N, N, N);
      rst_n = 1;
      clr();                step("idle", N, N, N);
      load_use(5, 0);       step("lu_0", S, S, S);
      clr();                step("lu_1", N, S, S);
                            step("lu_2", N, S, S);
                            step("lu_3", N, N, S);
                            step("lu_4", N, N, S);
                            step("lu_5", N, N, N);
      load_use(0, 0);       step("r0", N, N, N);
      load_use(7, 1); id_use_rt = 0; id_rs = 3; id_use_rs = 1;
                            step("rt_unused", N, N, N);
      clr(); id_branch = 1; id_rs = 9; id_use_rs = 1;
      mem_memread = 1; mem_regwrite = 1; mem_dst = 9;
                            step("bm", S, S, S);
      clr();                step("bm_end", N, N, N);
      id_jr = 1; id_rs = 4; id_use_rs = 1; ex_regwrite = 1; ex_dst = 4;
                            step("bx_jr", S, S, S);
      clr();                step("bx_end", N, N, N);
      id_branch = 1; id_rs = 8; id_use_rs = 1; mem_regwrite = 1; mem_dst = 8;
                            step("mem_alu", N, N, N);
      load_use(6, 0); id_branch = 1; id_taken = 1;
                            step("lu_bx_tk", S, S, S);
      clr(); id_taken = 1;  step("tk_1", F, S, S);
                            step("tk_2", F, S, S);
                            step("tk_3", F, F, S);
      clr();                step("tk_4", N, N, S);
                            step("tk_5", N, N, N);
      load_use(11, 0);      step("rlu_0", S, S, S);
      clr();                step("rlu_1", N, S, S);
      rst_n = 0;            step("rlu_rst", N, N, N);
      rst_n = 1;            step("post_rst", N, N, N);
                            step("post_rst2", N, N, N);
      load_use(12, 1);      step("lu_rt_0", S, S, S);
      clr();                step("lu_rt_1", N, S, S);
                            step("lu_rt_2", N, S, S);
                            step("lu_rt_3", N, N, S);
                            step("lu_rt_4", N, N, S);
                            step("lu_rt_5", N, N, N);
      if (q.size() != 0) begin
         errs++;
         $display("FAIL scoreboard observed=%0d expected=0 leftover", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
      $finish;
   end
endmodule
